// File: rtl/halt_controller_pkg.sv
// Shared opcode definitions and halt FSM state encoding for the decode-stage halt controller.
package halt_controller_pkg;

  localparam int WORD_SIZE = 16;

  localparam logic [3:0] OPCODE_RRR = 4'h1;
  localparam logic [5:0] FUNC_HLT   = 6'h2A;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } halt_state_e;

endpackage

// File: rtl/halt_controller.sv
// Detects HLT in decode, stops fetch, drains the pipeline for DRAIN_CYCLES unstalled cycles, then halts.
// Optional macro HALT_RESUME_EN adds a resume input that leaves HALTED.
module halt_controller
  import halt_controller_pkg::*;
#(
  parameter int WORD_SIZE    = halt_controller_pkg::WORD_SIZE,
  parameter int DRAIN_CYCLES = 4,
  localparam int CNT_W       = $clog2(DRAIN_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] instruction,
  input  logic                 inst_valid,
  input  logic                 flush,
  input  logic                 stall,
`ifdef HALT_RESUME_EN
  input  logic                 resume,
`endif
  output logic                 stop_fetch,
  output logic                 is_halted,
  output logic [CNT_W-1:0]     drain_cnt
);

  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  halt_state_e state;
  logic        hlt_match;
  logic        unused_bits;

  // An X/Z bit makes the equality unknown, which the if below treats as no match.
  assign hlt_match   = inst_valid
                     && (instruction[15:12] == OPCODE_RRR)
                     && (instruction[5:0]   == FUNC_HLT);
  assign unused_bits = ^instruction;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      stop_fetch <= 1'b0;
      is_halted  <= 1'b0;
      drain_cnt  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (hlt_match && !flush) begin
            state      <= ST_DRAIN;
            stop_fetch <= 1'b1;
            drain_cnt  <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          // A flush means the HLT was speculative; it wins over stall.
          if (flush) begin
            state      <= ST_RUN;
            stop_fetch <= 1'b0;
            drain_cnt  <= '0;
          end else if (!stall) begin
            if (drain_cnt == '0) begin
              state     <= ST_HALTED;
              is_halted <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt - CNT_W'(1);
            end
          end
        end
        ST_HALTED: begin
`ifdef HALT_RESUME_EN
          if (resume) begin
            state      <= ST_RUN;
            stop_fetch <= 1'b0;
            is_halted  <= 1'b0;
          end
`endif
        end
        default: begin
          state      <= ST_RUN;
          stop_fetch <= 1'b0;
          is_halted  <= 1'b0;
          drain_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_halt_controller.sv
// Scoreboard bench for halt_controller: stimulus pushes predicted outputs, a monitor pops and compares.
module tb_halt_controller;

  localparam int         DRAIN   = 4;
  localparam int         CW      = $clog2(DRAIN + 1);
  localparam logic [3:0] OPC     = 4'h1;
  localparam logic [5:0] FUNC    = 6'h2A;

  typedef struct {
    bit sf;
    bit hl;
    int cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   instruction = 16'h0000;
  logic          inst_valid = 1'b0;
  logic          flush = 1'b0;
  logic          stall = 1'b0;
  logic          resume = 1'b0;
  logic          stop_fetch;
  logic          is_halted;
  logic [CW-1:0] drain_cnt;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  exp_t cur;

  // Reference model: remaining unstalled drain cycles (0 = not draining) and a halted flag.
  int   remain = 0;
  bit   halted = 1'b0;

  halt_controller #(.WORD_SIZE(16), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk),
    .reset(reset),
    .instruction(instruction),
    .inst_valid(inst_valid),
    .flush(flush),
    .stall(stall),
`ifdef HALT_RESUME_EN
    .resume(resume),
`endif
    .stop_fetch(stop_fetch),
    .is_halted(is_halted),
    .drain_cnt(drain_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit is_hlt(logic [15:0] ins, logic v);
    if ($isunknown(ins) || $isunknown(v)) return 1'b0;
    return v && (ins[15:12] == OPC) && (ins[5:0] == FUNC);
  endfunction

  task automatic cyc(bit rst, logic [15:0] ins, logic v, bit fl, bit st, bit rs);
    exp_t e;
    @(negedge clk);
    reset = rst; instruction = ins; inst_valid = v; flush = fl; stall = st; resume = rs;
    if (rst) begin
      remain = 0; halted = 1'b0;
    end else if (halted) begin
`ifdef HALT_RESUME_EN
      if (rs) halted = 1'b0;
`endif
    end else if (remain > 0) begin
      if (fl) remain = 0;
      else if (!st) begin
        remain = remain - 1;
        if (remain == 0) halted = 1'b1;
      end
    end else if (is_hlt(ins, v) && !fl) begin
      remain = DRAIN;
    end
    e.sf  = (remain > 0) || halted;
    e.hl  = halted;
    e.cnt = (remain > 0) ? remain - 1 : 0;
    exp_q.push_back(e);
  endtask

  function automatic logic [15:0] hlt_word();
    logic [5:0] mid = 6'($urandom);
    return {OPC, mid, FUNC};
  endfunction

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'(($urandom & 16'h0FC0) | 16'h2000), 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hlt(bit fl);
    cyc(1'b0, hlt_word(), 1'b1, fl, 1'b0, 1'b0);
  endtask

  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      n_cmp++;
      if (stop_fetch !== cur.sf) begin
        n_bad++;
        $display("FAIL stop_fetch t=%0t got %b want %b", $time, stop_fetch, cur.sf);
      end
      n_cmp++;
      if (is_halted !== cur.hl) begin
        n_bad++;
        $display("FAIL is_halted t=%0t got %b want %b", $time, is_halted, cur.hl);
      end
      n_cmp++;
      if (drain_cnt !== CW'(cur.cnt)) begin
        n_bad++;
        $display("FAIL drain_cnt t=%0t got %0d want %0d", $time, drain_cnt, cur.cnt);
      end
    end
  end

  initial begin
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, hlt_word(), 1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    // Plain halt, then a second HLT in HALTED, then reset out of HALTED.
    hlt(1'b0);
    idle(8);
    hlt(1'b0);
    idle(2);
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    // HLT squashed in the same cycle.
    hlt(1'b1);
    idle(6);
    // HLT, flush two cycles later, then a clean HLT.
    hlt(1'b0);
    idle(1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    hlt(1'b0);
    idle(8);
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    // Three stalled cycles during drain.
    hlt(1'b0);
    idle(1);
    for (int i = 0; i < 3; i++) cyc(1'b0, hlt_word(), 1'b1, 1'b0, 1'b1, 1'b0);
    idle(8);
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    // Reset mid-drain, with an HLT and flush presented in the same cycle.
    hlt(1'b0);
    idle(2);
    cyc(1'b1, hlt_word(), 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3);
    // Unknown instruction word must not start a drain.
    cyc(1'b0, 16'hxxxx, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    // Resume out of HALTED, then halt again.
    hlt(1'b0);
    idle(6);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    hlt(1'b0);
    idle(7);
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] w;
      w = ($urandom_range(0, 3) == 0) ? hlt_word() : 16'($urandom);
      cyc(($urandom_range(0, 49) == 0), w, 1'($urandom),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 7) == 0));
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_queue left %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/halt_controller.md
HALT_CONTROLLER -- requirements
Module: halt_controller

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 16: instruction width, at least 16.
REQ-002 The block SHALL have parameter DRAIN_CYCLES, default 4: unstalled cycles from HLT detection to halted, range 1..255.
REQ-003 The block SHALL have localparam CNT_W = $clog2(DRAIN_CYCLES+1): drain counter width.
REQ-004 The block SHALL have port clk, input, 1: sole clock, all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 The block SHALL have port instruction, input, WORD_SIZE: instruction word in the decode stage.
REQ-007 The block SHALL have port inst_valid, input, 1: instruction is a real, non-bubble instruction this cycle.
REQ-008 The block SHALL have port flush, input, 1: decode-stage contents are squashed this cycle (mispredict).
REQ-009 The block SHALL have port stall, input, 1: the pipeline is frozen this cycle and the drain does not advance.
REQ-010 The block SHALL have port stop_fetch, output, 1: the fetch unit stops issuing, high in DRAIN and HALTED.
REQ-011 The block SHALL have port is_halted, output, 1: the pipeline is drained and the CPU is halted, high in HALTED only.
REQ-012 The block SHALL have port drain_cnt, output, CNT_W: remaining drain cycles, zero outside DRAIN.

Function
REQ-013 The HLT match SHALL be: inst_valid=1, opcode field instruction[15:12] equal to OPCODE_RRR, and function field instruction[5:0] equal to FUNC_HLT; any X or Z bit SHALL count as a non-match.
REQ-014 The FSM SHALL have the states RUN, DRAIN and HALTED, all registered.
REQ-015 In RUN, an HLT match with flush=0 SHALL move the FSM to DRAIN and load drain_cnt with DRAIN_CYCLES-1 at the same edge.
REQ-016 In RUN, an HLT match with flush=1 in the same cycle SHALL be ignored.
REQ-017 In DRAIN, flush=1 SHALL return the FSM to RUN and clear drain_cnt, because the HLT was speculative; flush SHALL take priority over stall.
REQ-018 In DRAIN with flush=0 and stall=1, the state and drain_cnt SHALL hold.
REQ-019 In DRAIN with flush=0 and stall=0, the FSM SHALL move to HALTED if drain_cnt=0; otherwise drain_cnt SHALL decrement by 1.
REQ-020 Latency: with no stalls, stop_fetch SHALL rise one cycle after the HLT cycle, and is_halted SHALL rise DRAIN_CYCLES cycles after stop_fetch.
REQ-021 In DRAIN and HALTED, instruction, inst_valid and stall SHALL be ignored, so a second HLT has no effect.
REQ-022 HALTED SHALL be sticky until reset, except as allowed by REQ-027.
REQ-023 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-024 When reset=1 at a rising edge, the block SHALL enter RUN with stop_fetch=0, is_halted=0 and drain_cnt=0, from any state including mid-DRAIN.
REQ-025 Reset SHALL override flush, stall and an HLT match in the same cycle.
REQ-026 The block SHALL have no initial-block dependence; power-up state is defined only by reset.

Configuration
REQ-027 When macro HALT_RESUME_EN is defined, the block SHALL add an input port resume (1 bit); resume=1 in HALTED SHALL return the FSM to RUN at the next edge, and resume SHALL be ignored in RUN and DRAIN.
REQ-028 When HALT_RESUME_EN is undefined, the resume port SHALL be absent and HALTED SHALL be left only by reset.

Structure
REQ-029 OPCODE_RRR, FUNC_HLT and WORD_SIZE SHALL come from the shared opcode definitions package, and the FSM state encoding SHALL live in that package.
REQ-030 The block SHALL be a single module with no sub-modules; the drain counter SHALL be inline.

Verification
REQ-031 With DRAIN_CYCLES=4, an HLT with inst_valid=1 at cycle 10 and no stalls SHALL give stop_fetch=1 from cycle 11, drain_cnt 3,2,1,0 on cycles 11-14, and is_halted=1 from cycle 15.
REQ-032 An HLT with flush=1 in the same cycle SHALL leave stop_fetch=0 and is_halted=0 on all following cycles.
REQ-033 An HLT, then flush=1 two cycles later, SHALL return the FSM to RUN with drain_cnt=0 and stop_fetch=0 on the next cycle; a later HLT SHALL halt normally.
REQ-034 An HLT with stall=1 for 3 cycles during DRAIN SHALL delay is_halted by exactly 3 cycles relative to REQ-031.
REQ-035 reset=1 asserted mid-DRAIN, and separately in HALTED, SHALL clear all outputs at the next edge; instruction=16'hxxxx SHALL never trigger DRAIN.
REQ-036 With HALT_RESUME_EN defined, resume=1 in HALTED SHALL return the FSM to RUN next cycle, and a second HLT SHALL halt again.
